// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one barrelshifter32 between two requesters using
// round-robin arbitration, with one registered result and valid/ready
// handshakes on both the request and response sides.
// Optional build macro SHIFT_ARB_STATS_EN adds saturating per-requester
// grant counters.

// 32-bit shifter: func3=1 selects left logical; otherwise right, and
// func7=1 makes the right shift arithmetic.
module barrelshifter32 (
    input  logic [31:0] data_i,
    input  logic [4:0]  shamt_i,
    input  logic        func3_i,
    input  logic        func7_i,
    output logic [31:0] result_o
);

    // Pick the shift operation from the function bits.
    always_comb begin
        if (func3_i) begin
            result_o = data_i << shamt_i;
        end else if (func7_i) begin
            result_o = 32'($signed(data_i) >>> shamt_i);
        end else begin
            result_o = data_i >> shamt_i;
        end
    end

endmodule

module shift_arbiter #(
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic        req0_left,
    input  logic        req0_arith,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic        req1_left,
    input  logic        req1_arith,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
`ifdef SHIFT_ARB_STATS_EN
    output logic [15:0] grant0_cnt,
    output logic [15:0] grant1_cnt,
`endif
    output logic [31:0] rsp_data
);

    localparam int unsigned DataW = 32;
    localparam int unsigned ShW   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               ptr_q,   ptr_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [DataW-1:0]   rsp_data_q, rsp_data_d;

    logic               grant0, grant1;
    logic               owner_ready;
    logic               can_accept;
    logic               accept;
    logic               acc_id;
    logic [DataW-1:0]   sh_data;
    logic [ShW-1:0]     sh_shamt;
    logic               sh_left;
    logic               sh_arith;
    logic [DataW-1:0]   sh_result;

    // Round-robin grant: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || (ptr_q == 1'b0));
        grant1 = req1_valid && (!req0_valid || (ptr_q == 1'b1));
    end

    // Accept when idle, or when the current result is being consumed.
    always_comb begin
        owner_ready = owner_q ? rsp1_ready : rsp0_ready;
        can_accept  = (state_q == IDLE) || owner_ready;
        req0_ready  = grant0 && can_accept;
        req1_ready  = grant1 && can_accept;
        accept      = req0_ready || req1_ready;
        acc_id      = req1_ready;
    end

    // Operand mux into the shared shifter; req0 fields when nothing is granted.
    always_comb begin
        if (grant1) begin
            sh_data  = req1_data;
            sh_shamt = req1_shamt;
            sh_left  = req1_left;
            sh_arith = req1_arith;
        end else begin
            sh_data  = req0_data;
            sh_shamt = req0_shamt;
            sh_left  = req0_left;
            sh_arith = req0_arith;
        end
    end

    barrelshifter32 u_shifter (
        .data_i   (sh_data),
        .shamt_i  (sh_shamt),
        .func3_i  (sh_left),
        .func7_i  (sh_arith),
        .result_o (sh_result)
    );

    // Next-state logic for the result register and ownership.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = HOLD;
                    owner_d      = acc_id;
                    ptr_d        = !acc_id;
                    rsp0_valid_d = !acc_id;
                    rsp1_valid_d = acc_id;
                    rsp_data_d   = sh_result;
                end
            end
            HOLD: begin
                if (owner_ready) begin
                    if (accept) begin
                        owner_d      = acc_id;
                        ptr_d        = !acc_id;
                        rsp0_valid_d = !acc_id;
                        rsp1_valid_d = acc_id;
                        rsp_data_d   = sh_result;
                    end else begin
                        state_d      = IDLE;
                        rsp0_valid_d = 1'b0;
                        rsp1_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            ptr_q        <= PRIO_RESET;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = rsp_data_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] grant0_cnt_q, grant0_cnt_d;
    logic [15:0] grant1_cnt_q, grant1_cnt_d;

    // Saturating accept counters.
    always_comb begin
        grant0_cnt_d = grant0_cnt_q;
        grant1_cnt_d = grant1_cnt_q;
        if (req0_ready && (grant0_cnt_q != 16'hFFFF)) begin
            grant0_cnt_d = grant0_cnt_q + 16'd1;
        end
        if (req1_ready && (grant1_cnt_q != 16'hFFFF)) begin
            grant1_cnt_d = grant1_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else begin
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (PRIO_RESET=0).
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_data = '0;
    logic [4:0]  req0_shamt = '0;
    logic        req0_left = 1'b0;
    logic        req0_arith = 1'b0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_data = '0;
    logic [4:0]  req1_shamt = '0;
    logic        req1_left = 1'b0;
    logic        req1_arith = 1'b0;
    logic        rsp0_valid;
    logic        rsp0_ready = 1'b1;
    logic        rsp1_valid;
    logic        rsp1_ready = 1'b1;
    logic [31:0] rsp_data;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] grant0_cnt;
    logic [15:0] grant1_cnt;
    logic [15:0] g1_before;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.PRIO_RESET(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_left  (req0_left),
        .req0_arith (req0_arith),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_left  (req1_left),
        .req1_arith (req1_arith),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
`ifdef SHIFT_ARB_STATS_EN
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt),
`endif
        .rsp_data   (rsp_data)
    );

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] d, input logic [4:0] s,
                        input logic l, input logic a);
        req0_valid = v; req0_data = d; req0_shamt = s; req0_left = l; req0_arith = a;
    endtask

    task automatic set1(input logic v, input logic [31:0] d, input logic [4:0] s,
                        input logic l, input logic a);
        req1_valid = v; req1_data = d; req1_shamt = s; req1_left = l; req1_arith = a;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);

        // Both valid after reset: req0 first, then req1
        set0(1'b1, 32'h0000_00F0, 5'd4, 1'b1, 1'b0);
        set1(1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b1);
        #1;
        check("tie_req0_ready", 32'(req0_ready), 32'd1);
        check("tie_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        check("c1_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("c1_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("c1_rsp_data", rsp_data, 32'h0000_0F00);
        req0_valid = 1'b0;
        #1;
        check("c1_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        check("c2_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("c2_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("c2_rsp_data", rsp_data, 32'hFFFF_FFFF);

        // req1 alone, logical right shift by 31
        set1(1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        #1;
        check("lsr_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        check("lsr_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("lsr_rsp_data", rsp_data, 32'h0000_0001);
        req1_valid = 1'b0;
        tick();
        check("drain_rsp1_valid", 32'(rsp1_valid), 32'd0);

        // Pointer now at req0: tie goes to req0; shamt=0 passes operand
        set0(1'b1, 32'h1234_5678, 5'd0, 1'b0, 1'b1);
        set1(1'b1, 32'h0000_00FF, 5'd8, 1'b1, 1'b1);
        rsp0_ready = 1'b0;
        #1;
        check("ptr_req0_ready", 32'(req0_ready), 32'd1);
        check("ptr_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
            check("stall_rsp_data", rsp_data, 32'h1234_5678);
            check("stall_req1_ready", 32'(req1_ready), 32'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        check("release_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        check("release_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("release_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("release_rsp_data", rsp_data, 32'h0000_FF00);

        // Fairness: both continuously valid, results every cycle
        set0(1'b1, 32'h0000_0001, 5'd1, 1'b1, 1'b0);
        set1(1'b1, 32'h0000_0080, 5'd4, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("rr_req0_ready", 32'(req0_ready), 32'((i % 2) == 0));
            check("rr_req1_ready", 32'(req1_ready), 32'((i % 2) == 1));
            tick();
            check("rr_rsp0_valid", 32'(rsp0_valid), 32'((i % 2) == 0));
            check("rr_rsp1_valid", 32'(rsp1_valid), 32'((i % 2) == 1));
            check("rr_rsp_data", rsp_data, ((i % 2) == 0) ? 32'h2 : 32'h8);
        end

        // Reset while holding a req0 result; pointer would otherwise favour req1
        req1_valid = 1'b0;
        tick();
        check("pre_rst_rsp0_valid", 32'(rsp0_valid), 32'd1);
        rsp0_ready = 1'b0;
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("mid_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("mid_rst_rsp_data", rsp_data, 32'd0);
        rsp0_ready = 1'b1;
        set0(1'b1, 32'hFFFF_0000, 5'd16, 1'b0, 1'b1);
        set1(1'b1, 32'h0000_0001, 5'd31, 1'b1, 1'b0);
        #1;
        check("mid_rst_ptr_req0", 32'(req0_ready), 32'd1);
        check("mid_rst_ptr_req1", 32'(req1_ready), 32'd0);
        tick();
        check("asr_rsp_data", rsp_data, 32'hFFFF_FFFF);
        req0_valid = 1'b0;
        tick();
        check("lsl31_rsp_data", rsp_data, 32'h8000_0000);

`ifdef SHIFT_ARB_STATS_EN
        req1_valid = 1'b0;
        tick();
        check("cnt0_now", 32'(grant0_cnt), 32'd1);
        check("cnt1_now", 32'(grant1_cnt), 32'd1);
        g1_before = grant1_cnt;
        req0_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        req0_valid = 1'b0;
        tick();
        check("cnt0_sat", 32'(grant0_cnt), 32'h0000_FFFF);
        check("cnt1_hold", 32'(grant1_cnt), 32'(g1_before));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Only one response valid at a time
    always @(negedge clk) begin
        if (rsp0_valid && rsp1_valid) begin
            check("onehot_rsp_valid", 32'd1, 32'd0);
        end
    end

endmodule
